// File: rtl/cpu_trap_pkg.sv
// Shared trap-controller definitions: FSM encodings, default cause codes and
// the default trap vector.
package cpu_trap_pkg;

  // FSM state encodings
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_WFI   = 3'd1;
  localparam logic [2:0] ST_DRAIN = 3'd2;
  localparam logic [2:0] ST_ENTER = 3'd3;
  localparam logic [2:0] ST_RET   = 3'd4;

  // Default mcause codes (interrupt bit set) and trap vector
  localparam logic [31:0] CAUSE_EXT_DEF = 32'h8000_000B;
  localparam logic [31:0] CAUSE_TMR_DEF = 32'h8000_0007;
  localparam logic [31:0] ISR_BASE_DEF  = 32'h0001_0000;

  // Fixed-priority cause pick: external beats timer
  function automatic logic [31:0] pick_cause(input logic ext,
                                             input logic [31:0] c_ext,
                                             input logic [31:0] c_tmr);
    return ext ? c_ext : c_tmr;
  endfunction

endpackage

// File: rtl/irq_pending_latch.sv
// Per-source interrupt pending flag: set by an enabled request level,
// cleared by the trap entry that takes it; set wins over clear.
module irq_pending_latch (
  input  logic clk,
  input  logic rst,
  input  logic irq,
  input  logic en,
  input  logic take,
  output logic pend
);

  logic set;
  assign set = irq & en;

  // Pending flag: set dominates a same-cycle clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       pend <= 1'b0;
    else if (set)  pend <= 1'b1;
    else if (take) pend <= 1'b0;
  end

endmodule

// File: rtl/trap_ctrl.sv
// Machine-mode trap sequencer: interrupt entry (drain then flush/redirect to
// the ISR), mret return to the saved mepc, and wfi sleep. All control outputs
// are decoded from the state and internal registers only.
module trap_ctrl
  import cpu_trap_pkg::*;
#(
  parameter logic [31:0] ISR_BASE  = ISR_BASE_DEF,
  parameter logic [31:0] CAUSE_EXT = CAUSE_EXT_DEF,
  parameter logic [31:0] CAUSE_TMR = CAUSE_TMR_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ext_irq,
  input  logic        tmr_irq,
  input  logic        mstatus_mie,
  input  logic        mie_meie,
  input  logic        mie_mtie,
  input  logic        wfi_req,
  input  logic        mret_req,
  input  logic        ex_valid,
  input  logic [31:0] ex_pc,
  input  logic [31:0] mepc_i,
  input  logic        im_stall,
  input  logic        dm_stall,
  output logic        pipe_hold,
  output logic        flush,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic        trap_take,
  output logic        mret_ack,
  output logic        mepc_we,
  output logic [31:0] mepc_wdata,
  output logic [31:0] mcause_wdata,
  output logic        ext_pend,
  output logic        tmr_pend
);

  logic [2:0]  state, state_nxt;
  logic [31:0] epc, cause, ret_pc;
  logic        stall_n, any_pend, in_enter, in_ret;
  logic        take_ext, take_tmr;

  assign stall_n  = ~im_stall & ~dm_stall;
  assign any_pend = ext_pend | tmr_pend;
  assign in_enter = (state == ST_ENTER);
  assign in_ret   = (state == ST_RET);

  // Only the cause latched for this entry is retired on the ENTER cycle
  assign take_ext = in_enter & (cause == CAUSE_EXT);
  assign take_tmr = in_enter & (cause == CAUSE_TMR);

  irq_pending_latch u_ext (
    .clk (clk), .rst (rst), .irq (ext_irq), .en (mie_meie),
    .take (take_ext), .pend (ext_pend)
  );

  irq_pending_latch u_tmr (
    .clk (clk), .rst (rst), .irq (tmr_irq), .en (mie_mtie),
    .take (take_tmr), .pend (tmr_pend)
  );

  // Next-state decode; mret outranks a simultaneous interrupt in IDLE
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (mret_req & stall_n)                      state_nxt = ST_RET;
        else if (any_pend & mstatus_mie & ex_valid)  state_nxt = ST_DRAIN;
        else if (wfi_req & stall_n)                  state_nxt = ST_WFI;
      end
      ST_WFI: begin
        if (any_pend) state_nxt = mstatus_mie ? ST_DRAIN : ST_IDLE;
      end
      ST_DRAIN: begin
        // Committed entry: only memory stalls can hold it here
        if (stall_n) state_nxt = ST_ENTER;
      end
      ST_ENTER: state_nxt = ST_IDLE;
      ST_RET:   state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Capture epc, cause and return target on the transitions that define them
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      epc    <= '0;
      cause  <= '0;
      ret_pc <= '0;
    end else begin
      if (state == ST_IDLE) begin
        if (mret_req & stall_n) begin
          ret_pc <= mepc_i;
        end else if (any_pend & mstatus_mie & ex_valid) begin
          epc   <= ex_pc;
          cause <= pick_cause(ext_pend, CAUSE_EXT, CAUSE_TMR);
        end else if (wfi_req & stall_n) begin
          epc <= ex_pc + 32'd4;  // resume after the wfi, wraps mod 2^32
        end
      end else if (state == ST_WFI) begin
        // epc already points past the wfi; only the cause is picked here
        if (any_pend & mstatus_mie)
          cause <= pick_cause(ext_pend, CAUSE_EXT, CAUSE_TMR);
      end
    end
  end

  // Output decode from state and registers
  always_comb begin
    pipe_hold      = (state == ST_WFI) | (state == ST_DRAIN);
    flush          = in_enter | in_ret;
    redirect_valid = in_enter | in_ret;
    redirect_pc    = in_enter ? ISR_BASE : (in_ret ? ret_pc : 32'd0);
    trap_take      = in_enter;
    mret_ack       = in_ret;
    mepc_we        = in_enter;
    mepc_wdata     = in_enter ? epc : 32'd0;
    mcause_wdata   = in_enter ? cause : 32'd0;
  end

endmodule
